adc_sample_pwm_out: RTL and testbench

//  Downstream stage of the AD7476A SPI capture block: consumes 12-bit ADC samples and drives the mono

---
 rtl/adc_sample_pwm_out.sv | 161 ++++++++++++++++
 tb/tb_adc_sample_pwm_out.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_pwm_out.sv
// Sample player: buffers ADC samples in a small FIFO and plays one per PWM period on amp_pwm.
// Define PWM_MUTE_TIMEOUT_EN to build the starvation mute state and its period counter.
module adc_sample_pwm_out #(
   parameter int DATA_W       = 12,
   parameter int CNT_W        = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int MUTE_PERIODS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_valid,
   output logic                        amp_pwm,
   output logic                        amp_sd,
   output logic                        overflow,
   output logic                        underflow,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
`ifdef PWM_MUTE_TIMEOUT_EN
      S_MUTE = 2'd2,
`endif
      S_OFF  = 2'd0,
      S_RUN  = 2'd1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  duty_q, duty_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              pwm_q, pwm_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [CNT_W-1:0]  mem_q [FIFO_DEPTH];
   logic              push, pop, boundary, empty, full, active;

`ifdef PWM_MUTE_TIMEOUT_EN
   localparam int MUTE_W = $clog2(MUTE_PERIODS + 1);
   localparam logic [MUTE_W-1:0] MUTE_LIM = MUTE_W'(MUTE_PERIODS);
   localparam logic [MUTE_W-1:0] MUTE_ONE = MUTE_W'(1);
   logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;
`else
   logic unused_mute_periods;
   assign unused_mute_periods = ^MUTE_PERIODS;
`endif

   // Only the duty-bearing MSBs are stored; the ADC LSBs are dropped at the input.
   if (DATA_W > CNT_W) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^s_data[DATA_W-CNT_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      duty_d      = duty_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = 1'b0;
      pwm_d       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      active      = (state_q != S_OFF);
      boundary    = active && (cnt_q == CNT_MAX);
      empty       = (level_q == '0);
      full        = (level_q == LVL_FULL);
`ifdef PWM_MUTE_TIMEOUT_EN
      mute_cnt_d  = mute_cnt_q;
`endif
      if (!enable) begin
         state_d  = S_OFF;
         cnt_d    = '0;
         duty_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
`ifdef PWM_MUTE_TIMEOUT_EN
         mute_cnt_d = '0;
`endif
      end else if (!active) begin
         state_d = S_RUN;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         // A boundary pop frees a slot, so a simultaneous push into a full FIFO is kept.
         pop   = boundary && !empty;
         push  = s_valid && (!full || pop);
         if (s_valid && !push) overflow_d = 1'b1;
         if (pop) begin
            duty_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
         underflow_d = boundary && empty && (state_q == S_RUN);
         pwm_d       = (state_q == S_RUN) && (cnt_q < duty_q);
`ifdef PWM_MUTE_TIMEOUT_EN
         if (pop) begin
            mute_cnt_d = '0;
            state_d    = S_RUN;
         end else if (underflow_d) begin
            mute_cnt_d = mute_cnt_q + MUTE_ONE;
            if (mute_cnt_d == MUTE_LIM) state_d = S_MUTE;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_OFF;
         cnt_q       <= '0;
         duty_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pwm_q       <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         duty_q      <= duty_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pwm_q       <= pwm_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef PWM_MUTE_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) mute_cnt_q <= '0;
      else     mute_cnt_q <= mute_cnt_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data[DATA_W-1 -: CNT_W];
   end

   assign amp_pwm   = pwm_q;
   assign amp_sd    = (state_q == S_RUN);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign level     = level_q;

endmodule

// File: tb/tb_adc_sample_pwm_out.sv
// Bench for adc_sample_pwm_out: directed scenarios plus random traffic against a queue-based model.
module tb_adc_sample_pwm_out;
   localparam int PERIOD = 256;
   localparam int DEPTH  = 4;
   localparam int MUTE_N = 16;
   localparam int BASE   = 257;
`ifdef PWM_MUTE_TIMEOUT_EN
   localparam bit MUTE_ON = 1'b1;
`else
   localparam bit MUTE_ON = 1'b0;
`endif

   logic        clk, rst, enable, s_valid;
   logic [11:0] s_data;
   logic        amp_pwm, amp_sd, overflow, underflow;
   logic [2:0]  level;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0=off 1=run 2=mute, phase within the period, queued samples.
   int          m_mode, m_phase, m_duty, m_starve;
   bit          m_over, e_pwm, e_under;
   logic [11:0] m_q [$];

   adc_sample_pwm_out dut (
      .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
      .amp_pwm(amp_pwm), .amp_sd(amp_sd), .overflow(overflow), .underflow(underflow),
      .level(level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model_step(bit r, bit en, bit sv, logic [11:0] sd);
      bit bnd;
      if (r) begin
         m_mode = 0; m_phase = 0; m_duty = 0; m_starve = 0;
         m_q.delete(); m_over = 0; e_pwm = 0; e_under = 0;
         return;
      end
      e_pwm   = en && (m_mode == 1) && (m_phase < m_duty);
      e_under = 0;
      if (!en) begin
         m_mode = 0; m_phase = 0; m_duty = 0; m_starve = 0;
         m_q.delete();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else begin
         bnd     = (m_phase == PERIOD - 1);
         m_phase = (m_phase + 1) % PERIOD;
         if (bnd && m_q.size() > 0) begin
            m_duty   = int'(m_q.pop_front() >> 4);
            m_starve = 0;
            m_mode   = 1;
         end else if (bnd && m_mode == 1) begin
            e_under  = 1;
            m_starve = m_starve + 1;
            if (MUTE_ON && m_starve == MUTE_N) m_mode = 2;
         end
         if (sv) begin
            if (m_q.size() < DEPTH) m_q.push_back(sd);
            else m_over = 1;
         end
      end
   endfunction

   function automatic logic [6:0] dut_vec();
      return {amp_pwm, amp_sd, underflow, overflow, level};
   endfunction

   function automatic logic [6:0] mdl_vec();
      return {e_pwm, (m_mode == 1), e_under, m_over, 3'(m_q.size())};
   endfunction

   task automatic tick(input bit r, input bit en, input bit sv, input logic [11:0] sd);
      rst = r; enable = en; s_valid = sv; s_data = sd;
      model_step(r, en, sv, sd);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 12'h000);
      tick(1, 1, 1, 12'hABC);
      total++;
      if (dut_vec() !== 7'b0) begin
         bad++; $display("FAIL reset_state dut=%b required=%b", dut_vec(), 7'b0);
      end
      for (int i = 0; i < 300; i++) begin
         tick(0, 1, (i == 3) || (i == 5), (i == 3) ? 12'hFF0 : 12'h123);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL reset_run i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
      end
      tick(1, 1, 0, 12'h000);
      total++;
      if (dut_vec() !== 7'b0) begin
         bad++; $display("FAIL reset_mid_period dut=%b required=%b", dut_vec(), 7'b0);
      end
   endtask

   task automatic test_play();
      int highs, w;
      int exp_h [4];
      bit sv;
      logic [11:0] sd;
      exp_h = '{255, 128, 0, 0};
      highs = 0;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < BASE + 4 * PERIOD; i++) begin
         sv = 1'b1;
         case (i)
            1:       sd = 12'hFFF;
            2:       sd = 12'h800;
            10:      sd = 12'h000;
            11:      sd = 12'h00F;
            default: begin sv = 1'b0; sd = 12'h000; end
         endcase
         tick(0, 1, sv, sd);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL play i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
         if (i >= BASE) begin
            w = (i - BASE) / PERIOD;
            if ((i - BASE) % PERIOD == 0) highs = 0;
            highs += int'(amp_pwm);
            if ((i - BASE) % PERIOD == PERIOD - 1) begin
               total++;
               if (highs !== exp_h[w]) begin
                  bad++; $display("FAIL play_duty period=%0d high=%0d required=%0d", w, highs, exp_h[w]);
               end
            end
         end
      end
      total++;
      if (amp_sd !== 1'b1) begin
         bad++; $display("FAIL play_amp_sd got=%b required=1", amp_sd);
      end
   endtask

   task automatic test_overflow();
      int highs, w;
      logic [11:0] s [6];
      for (int k = 0; k < 6; k++) s[k] = 12'($urandom);
      highs = 0;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < BASE + 4 * PERIOD; i++) begin
         tick(0, 1, (i >= 1 && i <= 6), (i >= 1 && i <= 6) ? s[i-1] : 12'h000);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL overflow i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
         if (i == 6) begin
            total++;
            if (level !== 3'd4 || overflow !== 1'b1) begin
               bad++; $display("FAIL overflow_flag level=%0d ovf=%b required level=4 ovf=1", level, overflow);
            end
         end
         if (i >= BASE) begin
            w = (i - BASE) / PERIOD;
            if ((i - BASE) % PERIOD == 0) highs = 0;
            highs += int'(amp_pwm);
            if ((i - BASE) % PERIOD == PERIOD - 1) begin
               total++;
               if (highs !== int'(s[w] >> 4)) begin
                  bad++; $display("FAIL overflow_order period=%0d high=%0d required=%0d", w, highs, int'(s[w] >> 4));
               end
            end
         end
      end
      total++;
      if (overflow !== 1'b1) begin
         bad++; $display("FAIL overflow_sticky got=%b required=1", overflow);
      end
   endtask

   task automatic test_full_boundary();
      int highs, w;
      logic [11:0] s [5];
      bit sv;
      for (int k = 0; k < 5; k++) s[k] = 12'($urandom);
      highs = 0;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < BASE + 4 * PERIOD; i++) begin
         sv = (i >= 1 && i <= 4) || (i == 256);
         tick(0, 1, sv, (i >= 1 && i <= 4) ? s[i-1] : s[4]);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL full_bnd i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
         if (i == 256) begin
            total++;
            if (level !== 3'd4 || overflow !== 1'b0) begin
               bad++; $display("FAIL full_bnd_push level=%0d ovf=%b required level=4 ovf=0", level, overflow);
            end
         end
         if (i >= BASE) begin
            w = (i - BASE) / PERIOD;
            if ((i - BASE) % PERIOD == 0) highs = 0;
            highs += int'(amp_pwm);
            if ((i - BASE) % PERIOD == PERIOD - 1) begin
               total++;
               if (highs !== int'(s[w] >> 4)) begin
                  bad++; $display("FAIL full_bnd_order period=%0d high=%0d required=%0d", w, highs, int'(s[w] >> 4));
               end
            end
         end
      end
   endtask

   task automatic test_starve();
      int highs, w, unders;
      logic [11:0] sa, sb;
      sa = 12'($urandom_range(16, 4095));
      sb = 12'($urandom_range(16, 4095));
      highs = 0; unders = 0;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < BASE + 18 * PERIOD; i++) begin
         tick(0, 1, (i == 1) || (i == BASE + 16 * PERIOD), (i == 1) ? sa : sb);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL starve i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
         if (i >= BASE) begin
            w = (i - BASE) / PERIOD;
            if ((i - BASE) % PERIOD == 0) highs = 0;
            if ((i - BASE) % PERIOD == 0 && (w == 0 || w == 16)) unders = 0;
            highs  += int'(amp_pwm);
            unders += int'(underflow);
            if (i == BASE + 16 * PERIOD - 1) begin
               total++;
               if (unders !== MUTE_N || highs !== int'(sa >> 4) || amp_sd !== !MUTE_ON) begin
                  bad++; $display("FAIL starve_16 underflows=%0d high=%0d sd=%b required %0d/%0d/%b",
                                  unders, highs, amp_sd, MUTE_N, int'(sa >> 4), !MUTE_ON);
               end
            end
            if (i == BASE + 17 * PERIOD - 1) begin
               total++;
               if (unders !== 0 || highs !== (MUTE_ON ? 0 : int'(sa >> 4)) || amp_sd !== 1'b1) begin
                  bad++; $display("FAIL starve_recover underflows=%0d high=%0d sd=%b required 0/%0d/1",
                                  unders, highs, amp_sd, MUTE_ON ? 0 : int'(sa >> 4));
               end
            end
            if (i == BASE + 18 * PERIOD - 1) begin
               total++;
               if (highs !== int'(sb >> 4)) begin
                  bad++; $display("FAIL starve_new_duty high=%0d required=%0d", highs, int'(sb >> 4));
               end
            end
         end
      end
   endtask

   task automatic test_disable();
      bit en, sv;
      logic [11:0] sd;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < 559; i++) begin
         en = !(i >= 297 && i <= 301);
         sv = (i >= 1 && i <= 3) || (i >= 298 && i <= 301) || (i == 303);
         sd = (i == 1) ? 12'hC80 : (i == 303) ? 12'hFF0 : 12'($urandom);
         tick(0, en, sv, sd);
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL disable i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
         if (i == 296 || i == 297) begin
            total++;
            if ({amp_pwm, amp_sd} !== ((i == 296) ? 2'b11 : 2'b00) || (i == 297 && level !== 3'd0)) begin
               bad++; $display("FAIL disable_edge i=%0d pwm=%b sd=%b level=%0d", i, amp_pwm, amp_sd, level);
            end
         end
         if (i == 301 || i == 557 || i == 558) begin
            total++;
            if (level !== ((i == 557) ? 3'd1 : 3'd0)) begin
               bad++; $display("FAIL disable_level i=%0d level=%0d required=%0d", i, level, (i == 557) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_random();
      bit r, en, sv;
      tick(1, 0, 0, 12'h000);
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 1999) == 0);
         en = ($urandom_range(0, 299) != 0);
         sv = ($urandom_range(0, 119) == 0);
         tick(r, en, sv, 12'($urandom));
         total++;
         if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL random i=%0d dut=%b model=%b", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 12'h000;
      test_reset();
      test_play();
      test_overflow();
      test_full_boundary();
      test_starve();
      test_disable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
